// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative forward AES MixColumns, one 32-bit column per clock.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   in_valid/ready - input handshake for state_in (128b) and bypass (final round)
//   out_valid/ready- output handshake for state_out (128b)
// Byte order follows FIPS-197: byte k = bits [127-8k -: 8], column c = bytes 4c..4c+3.
module mix_columns_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [STATE_W-1:0] src, src_nxt;
  logic [STATE_W-1:0] dst, dst_nxt;
  logic [1:0]         col, col_nxt;
  logic               byp, byp_nxt;
  logic               valid, valid_nxt;
  logic [COL_W-1:0]   cur_col;
  logic [COL_W-1:0]   mixed_col;

  // Multiply by 02 in GF(2^8), reduction polynomial 0x1B.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // One MixColumns column: a0 is the most significant byte.
  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = a[31:24];
    a1 = a[23:16];
    a2 = a[15:8];
    a3 = a[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // Select the source column addressed by the counter.
  always_comb begin
    cur_col = src[127:96];
    case (col)
      2'd0: cur_col = src[127:96];
      2'd1: cur_col = src[95:64];
      2'd2: cur_col = src[63:32];
      2'd3: cur_col = src[31:0];
      default: cur_col = src[127:96];
    endcase
  end

  assign mixed_col = mix_col(cur_col);

  // Next-state and datapath update.
  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    dst_nxt   = dst;
    col_nxt   = col;
    byp_nxt   = byp;
    valid_nxt = valid;
    case (state)
      IDLE: begin
        if (in_valid) begin
          src_nxt = state_in;
          byp_nxt = bypass;
          col_nxt = 2'd0;
          if (bypass) begin
            dst_nxt   = state_in;
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        case (col)
          2'd0: dst_nxt[127:96] = mixed_col;
          2'd1: dst_nxt[95:64]  = mixed_col;
          2'd2: dst_nxt[63:32]  = mixed_col;
          2'd3: dst_nxt[31:0]   = mixed_col;
          default: dst_nxt = dst;
        endcase
        col_nxt = col + 2'd1;
        if (col == 2'd3) begin
          state_nxt = DONE;
          valid_nxt = 1'b1;
        end
      end
      DONE: begin
        if (valid && out_ready) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end else if (byp) begin
          // Bypass enters DONE straight from IDLE; valid follows one cycle later.
          valid_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      col   <= 2'd0;
      byp   <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      src   <= src_nxt;
      dst   <= dst_nxt;
      col   <= col_nxt;
      byp   <= byp_nxt;
      valid <= valid_nxt;
    end
  end

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = valid;
  assign state_out = dst;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed-vector bench for mix_columns_seq.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COL1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] COL1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] COL2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
  localparam logic [127:0] COL2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
  localparam logic [127:0] BYP_IN   = 128'h00112233445566778899aabbccddeeff;

  mix_columns_seq dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a state for one accept edge, then drop in_valid.
  task automatic accept(input logic [127:0] data, input logic byp_bit);
    state_in = data;
    bypass   = byp_bit;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    state_in = ~data;
    bypass   = ~byp_bit;
  endtask

  // Wait (bounded) for out_valid; returns cycles counted after the accept edge.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    if (!out_valid) check({tag, "_timeout"}, 128'(out_valid), 128'(1));
  endtask

  // Full transaction with out_ready held high.
  task automatic run(input string tag, input logic [127:0] data, input logic byp_bit,
                     input logic [127:0] exp, input int exp_lat);
    int lat;
    out_ready = 1'b1;
    accept(data, byp_bit);
    check({tag, "_busy_ready"}, 128'(in_ready), 128'(0));
    wait_valid(tag, lat);
    check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    check({tag, "_data"}, state_out, exp);
    tick();
    check({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
    check({tag, "_ready_back"}, 128'(in_ready), 128'(1));
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    state_in  = '0;
    bypass    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_state_out", state_out, 128'h0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));

    // Main function, normal and bypass paths.
    run("fips", FIPS_IN, 1'b0, FIPS_OUT, 4);
    run("col1", COL1_IN, 1'b0, COL1_OUT, 4);
    run("col2", COL2_IN, 1'b0, COL2_OUT, 4);
    run("byp", BYP_IN, 1'b1, BYP_IN, 1);

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    accept(FIPS_IN, 1'b0);
    wait_valid("bp", lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 128'(out_valid), 128'(1));
      check("bp_hold_data", state_out, FIPS_OUT);
      check("bp_hold_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_ready", 128'(in_ready), 128'(1));

    // Reset during the second BUSY cycle discards the transaction.
    accept(COL1_IN, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 128'(out_valid), 128'(0));
    check("mid_rst_data", state_out, 128'h0);
    check("mid_rst_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 6; i++) begin
      tick();
      check("mid_rst_quiet", 128'(out_valid), 128'(0));
    end
    run("after_rst", FIPS_IN, 1'b0, FIPS_OUT, 4);

    // in_valid pulses in BUSY and DONE are ignored.
    out_ready = 1'b0;
    accept(COL2_IN, 1'b0);
    tick();
    state_in = COL1_IN;
    bypass   = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid("ign", lat);
    state_in = BYP_IN;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("ign_done_data", state_out, COL2_OUT);
    check("ign_done_valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    tick();
    check("ign_release_valid", 128'(out_valid), 128'(0));
    check("ign_release_data", state_out, COL2_OUT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
